// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RISC-V control unit:
// FSM states, opcodes, ALU operation selects and datapath mux selects.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_ERROR
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_sel_e;

    // Which funct table the ALU decoder applies in the current state.
    typedef enum logic [1:0] {
        DEC_ADD,
        DEC_BRANCH,
        DEC_RTYPE,
        DEC_ITYPE
    } dec_class_e;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] alu_sel;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct decode: maps the instruction class, funct3 and funct7[5]
// to the ALU operation select, flagging funct combinations the core does not support.
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  dec_class_e i_class,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [2:0] o_alu_sel,
    output logic       o_illegal_funct
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
        o_alu_sel       = ALU_ADD;
        o_illegal_funct = 1'b0;
        case (i_class)
            DEC_BRANCH: begin
                case (i_funct3)
                    3'b000, 3'b001: o_alu_sel = ALU_SUB;
                    3'b100:         o_alu_sel = ALU_SLT;
                    default:        o_illegal_funct = 1'b1;
                endcase
            end
            DEC_RTYPE, DEC_ITYPE: begin
                case (i_funct3)
                    3'b000:  o_alu_sel = (i_class == DEC_RTYPE && i_funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b111:  o_alu_sel = ALU_AND;
                    3'b110:  o_alu_sel = ALU_OR;
                    3'b010:  o_alu_sel = ALU_SLT;
                    default: o_illegal_funct = 1'b1;
                endcase
            end
            default: o_alu_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath enables, mux selects and ALU operation.
module riscv_mc_control
    import riscv_mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        adr_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [2:0]  alu_sel,
    output logic        illegal
);

    state_e     r_state;
    state_e     w_next;
    ctrl_t      w_ctrl;
    dec_class_e w_class;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [2:0] w_dec_sel;
    logic       w_illegal_funct;
    logic       w_unused;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    // Register and immediate fields belong to the datapath, not to control.
    assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        case (r_state)
            S_EXEC_R: w_class = DEC_RTYPE;
            S_EXEC_I: w_class = DEC_ITYPE;
            S_BRANCH: w_class = DEC_BRANCH;
            default:  w_class = DEC_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_class         (w_class),
        .i_funct3        (w_funct3),
        .i_funct7_5      (instr[30]),
        .o_alu_sel       (w_dec_sel),
        .o_illegal_funct (w_illegal_funct)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.adr_src    = ADR_PC;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.alu_src_a  = SRCA_PC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALU;
                if (mem_ready) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_next          = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jump target lands in ALUOut while the opcode is examined.
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                case (w_opcode)
                    OP_RTYPE:          w_next = S_EXEC_R;
                    OP_ITYPE:          w_next = S_EXEC_I;
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADR;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    default:           w_next = S_ERROR;
                endcase
            end
            S_EXEC_R, S_EXEC_I: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = (r_state == S_EXEC_R) ? SRCB_RS2 : SRCB_IMM;
                w_ctrl.alu_sel   = w_dec_sel;
                w_next           = w_illegal_funct ? S_ERROR : S_ALU_WB;
            end
            S_ALU_WB: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
                w_next            = S_FETCH;
            end
            S_MEM_ADR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_next           = (w_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_ctrl.adr_src  = ADR_ALUOUT;
                w_ctrl.mem_read = 1'b1;
                if (mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_ctrl.result_src = RES_DATA;
                w_ctrl.reg_write  = 1'b1;
                w_next            = S_FETCH;
            end
            S_MEM_WR: begin
                w_ctrl.adr_src   = ADR_ALUOUT;
                w_ctrl.mem_write = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a  = SRCA_RS1;
                w_ctrl.alu_src_b  = SRCB_RS2;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.alu_sel    = w_dec_sel;
                if (w_illegal_funct) begin
                    w_next = S_ERROR;
                end else begin
                    // beq takes on zero; bne and blt (slt result of 1) take on non-zero.
                    w_ctrl.pc_write = (w_funct3 == 3'b000) ? zero : !zero;
                    w_next          = S_FETCH;
                end
            end
            S_JAL: begin
                w_ctrl.alu_src_a  = SRCA_OLDPC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.pc_write   = 1'b1;
                w_next            = S_ALU_WB;
            end
            S_ERROR: begin
                w_ctrl.illegal = 1'b1;
            end
            default: begin
                w_next = S_ERROR;
            end
        endcase
        // Outputs are held quiet for the whole time reset is asserted, not just from the next edge.
        if (!rst_n) w_ctrl = '0;
    end

    assign pc_write   = w_ctrl.pc_write;
    assign ir_write   = w_ctrl.ir_write;
    assign adr_src    = w_ctrl.adr_src;
    assign mem_read   = w_ctrl.mem_read;
    assign mem_write  = w_ctrl.mem_write;
    assign reg_write  = w_ctrl.reg_write;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign result_src = w_ctrl.result_src;
    assign alu_sel    = w_ctrl.alu_sel;
    assign illegal    = w_ctrl.illegal;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Scoreboard bench for riscv_mc_control: an instruction-level model queues the
// expected control word for every cycle, and a negedge monitor compares the DUT against it.
module tb_riscv_mc_control;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] A_ADD = 3'b000;
    localparam logic [2:0] A_SUB = 3'b001;
    localparam logic [2:0] A_AND = 3'b010;
    localparam logic [2:0] A_OR  = 3'b011;
    localparam logic [2:0] A_SLT = 3'b101;

    // Control word layout: {pcw, irw, adr, mrd, mwr, rw, a[1:0], b[1:0], res[1:0], sel[2:0], ill}
    localparam logic [15:0] M_ALL   = 16'hFFFF;
    localparam logic [15:0] M_FWAIT = 16'hFF0F;
    localparam logic [15:0] M_NOSEL = 16'hFFF1;

    localparam int PH_RESET  = 0;
    localparam int PH_FETCH  = 1;
    localparam int PH_DECODE = 2;
    localparam int PH_EXEC   = 3;
    localparam int PH_ALUWB  = 4;
    localparam int PH_MADR   = 5;
    localparam int PH_MRD    = 6;
    localparam int PH_MWB    = 7;
    localparam int PH_MWR    = 8;
    localparam int PH_BRANCH = 9;
    localparam int PH_JAL    = 10;
    localparam int PH_ERROR  = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  alu_sel;
    logic        illegal;
    logic [15:0] out_vec;

    typedef struct {
        logic [15:0] vec;
        logic [15:0] mask;
        int          phase;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    riscv_mc_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .adr_src    (adr_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_sel    (alu_sel),
        .illegal    (illegal)
    );

    assign out_vec = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                      alu_src_a, alu_src_b, result_src, alu_sel, illegal};

    always #5 clk = ~clk;

    function automatic string phase_name(input int ph);
        case (ph)
            PH_RESET:  return "reset";
            PH_FETCH:  return "fetch";
            PH_DECODE: return "decode";
            PH_EXEC:   return "execute";
            PH_ALUWB:  return "alu_writeback";
            PH_MADR:   return "mem_address";
            PH_MRD:    return "mem_read";
            PH_MWB:    return "mem_writeback";
            PH_MWR:    return "mem_write";
            PH_BRANCH: return "branch";
            PH_JAL:    return "jal";
            PH_ERROR:  return "error";
            default:   return "unknown";
        endcase
    endfunction

    function automatic logic [15:0] ov(input logic pcw, irw, adr, mrd, mwr, rw,
                                       input logic [1:0] a, b, res,
                                       input logic [2:0] sel, input logic ill);
        return {pcw, irw, adr, mrd, mwr, rw, a, b, res, sel, ill};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp, input logic [15:0] mask);
        n_cmp++;
        if ((act & mask) !== (exp & mask)) begin
            n_err++;
            $display("FAIL %s at %0t: got %b required %b (mask %b)", name, $time, act, exp, mask);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check(phase_name(mon_e.phase), out_vec, mon_e.vec, mon_e.mask);
        end
    end

    task automatic push_exp(input logic [15:0] e, input logic [15:0] m, input int ph);
        exp_t x;
        x.vec   = e;
        x.mask  = m;
        x.phase = ph;
        sb_q.push_back(x);
    endtask

    // One clock of stimulus: drive inputs just after the edge and queue what that cycle must show.
    task automatic cyc(input logic mr, input logic z, input logic [15:0] e,
                       input logic [15:0] m, input int ph);
        mem_ready = mr;
        zero      = z;
        push_exp(e, m, ph);
        @(posedge clk);
        #1;
    endtask

    task automatic ref_funct(input logic [2:0] f3, input logic f7_5, input bit is_r,
                             output bit ok, output logic [2:0] sel);
        ok = 1'b1;
        case (f3)
            3'b000:  sel = (is_r && f7_5) ? A_SUB : A_ADD;
            3'b111:  sel = A_AND;
            3'b110:  sel = A_OR;
            3'b010:  sel = A_SLT;
            default: begin ok = 1'b0; sel = A_ADD; end
        endcase
    endtask

    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        repeat (n) cyc(rb(), rb(), 16'h0000, M_ALL, PH_RESET);
        rst_n = 1'b1;
    endtask

    task automatic error_then_reset();
        repeat ($urandom_range(2, 4))
            cyc(rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,A_ADD,1'b1), M_ALL, PH_ERROR);
        hold_reset($urandom_range(1, 2));
    endtask

    task automatic do_fetch(input int fw);
        repeat (fw)
            cyc(1'b0, rb(), ov(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,2'd0,2'd0,A_ADD,1'b0), M_FWAIT, PH_FETCH);
        cyc(1'b1, rb(), ov(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,2'd2,2'd2,A_ADD,1'b0), M_ALL, PH_FETCH);
    endtask

    // Instruction-level reference: emits the expected control word for each cycle the instruction takes.
    task automatic do_instr(input logic [31:0] ins, input int fw, input int mw, input logic zb);
        logic [6:0] op;
        logic [2:0] f3;
        logic [2:0] sel;
        logic       tk;
        bit         ok;
        op = ins[6:0];
        f3 = ins[14:12];
        do_fetch(fw);
        instr = ins;
        cyc(rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd1,2'd0,A_ADD,1'b0), M_ALL, PH_DECODE);
        case (op)
            OPC_R, OPC_I: begin
                ref_funct(f3, ins[30], op == OPC_R, ok, sel);
                cyc(rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,(op == OPC_R) ? 2'd0 : 2'd1,2'd0,sel,1'b0),
                    ok ? M_ALL : M_NOSEL, PH_EXEC);
                if (ok)
                    cyc(rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,2'd0,A_ADD,1'b0), M_ALL, PH_ALUWB);
                else
                    error_then_reset();
            end
            OPC_LOAD: begin
                cyc(rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd1,2'd0,A_ADD,1'b0), M_ALL, PH_MADR);
                repeat (mw)
                    cyc(1'b0, rb(), ov(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,2'd0,2'd0,A_ADD,1'b0), M_ALL, PH_MRD);
                cyc(1'b1, rb(), ov(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,2'd0,2'd0,A_ADD,1'b0), M_ALL, PH_MRD);
                cyc(rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,2'd1,A_ADD,1'b0), M_ALL, PH_MWB);
            end
            OPC_STORE: begin
                cyc(rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd1,2'd0,A_ADD,1'b0), M_ALL, PH_MADR);
                repeat (mw)
                    cyc(1'b0, rb(), ov(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,A_ADD,1'b0), M_ALL, PH_MWR);
                cyc(1'b1, rb(), ov(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,A_ADD,1'b0), M_ALL, PH_MWR);
            end
            OPC_BRANCH: begin
                ok = 1'b1;
                case (f3)
                    3'b000:  begin sel = A_SUB; tk = zb;  end
                    3'b001:  begin sel = A_SUB; tk = !zb; end
                    3'b100:  begin sel = A_SLT; tk = !zb; end
                    default: begin sel = A_ADD; tk = 1'b0; ok = 1'b0; end
                endcase
                cyc(rb(), zb, ov(tk,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd0,sel,1'b0),
                    ok ? M_ALL : M_NOSEL, PH_BRANCH);
                if (!ok) error_then_reset();
            end
            OPC_JAL: begin
                cyc(rb(), rb(), ov(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd2,2'd0,A_ADD,1'b0), M_ALL, PH_JAL);
                cyc(rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,2'd0,A_ADD,1'b0), M_ALL, PH_ALUWB);
            end
            default: error_then_reset();
        endcase
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [2:0]  legal3 [4];
        logic [1:0]  idx;
        int          k;
        legal3 = '{3'b000, 3'b010, 3'b110, 3'b111};
        r      = $urandom();
        k      = $urandom_range(0, 19);
        idx    = 2'($urandom_range(0, 3));
        if (k < 8) begin
            r[6:0] = (k < 4) ? OPC_R : OPC_I;
            if ($urandom_range(0, 4) != 0) r[14:12] = legal3[idx];
        end else if (k < 10) begin
            r[6:0] = OPC_LOAD;
        end else if (k < 12) begin
            r[6:0] = OPC_STORE;
        end else if (k < 16) begin
            r[6:0] = OPC_BRANCH;
            if ($urandom_range(0, 5) != 0) r[14:12] = (k == 12) ? 3'b000 : (k == 13) ? 3'b001 : 3'b100;
        end else if (k < 18) begin
            r[6:0] = OPC_JAL;
        end
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        instr     = 32'h0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        hold_reset(2);

        do_instr(32'h002081B3, 0, 0, 1'b0);   // add x3,x1,x2
        do_instr(32'h402081B3, 0, 0, 1'b0);   // sub x3,x1,x2
        do_instr(32'h0050E193, 1, 0, 1'b0);   // ori x3,x1,5
        do_instr(32'h0000A283, 0, 3, 1'b0);   // lw  x5,0(x1), three wait states
        do_instr(32'h00208063, 0, 0, 1'b1);   // beq taken
        do_instr(32'h00208063, 0, 0, 1'b0);   // beq not taken
        do_instr(32'h00209063, 0, 0, 1'b1);   // bne with zero
        do_instr(32'h0020C063, 0, 0, 1'b0);   // blt taken
        do_instr(32'h0020A023, 2, 1, 1'b0);   // sw  x2,0(x1)
        do_instr(32'h000000EF, 0, 0, 1'b0);   // jal x1,0
        do_instr(32'h0000007F, 0, 0, 1'b0);   // unsupported opcode
        do_instr(32'h002091B3, 0, 0, 1'b0);   // R-type funct3 001

        // Reset dropped in the middle of a stalled store.
        do_fetch(0);
        instr = 32'h0020A023;
        cyc(rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd1,2'd0,A_ADD,1'b0), M_ALL, PH_DECODE);
        cyc(rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd1,2'd0,A_ADD,1'b0), M_ALL, PH_MADR);
        mem_ready = 1'b0;
        push_exp(ov(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,A_ADD,1'b0), M_ALL, PH_MWR);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", out_vec, 16'h0000, M_ALL);
        @(posedge clk);
        #1;
        hold_reset(1);
        do_instr(32'h002081B3, 0, 0, 1'b0);

        for (int i = 0; i < 200; i++)
            do_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2), rb());

        repeat (2) @(posedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
